// File: rtl/rptr_fwft.sv
// Read-side controller of the async FIFO, entirely in the rclk domain.
// Keeps the binary and Gray read pointers, derives registered empty,
// almost-empty and fill level from the synchronised write pointer, issues
// reads to the 1-cycle-latency memory port and presents words
// first-word-fall-through through a 2-entry output buffer.
module rptr_fwft #(
  parameter int ADDRSIZE      = 4,
  parameter int DATASIZE      = 8,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr_sync,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic                ren,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                empty,
  output logic                aempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready
);

  localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AEMPTY_THRESH);

  // Pointer and status flops
  logic [ADDRSIZE:0]   rbin_q, rbin_d;
  logic [ADDRSIZE:0]   rptr_q, rptr_d;
  logic                empty_q, empty_d;
  logic                aempty_q, aempty_d;
  logic [ADDRSIZE:0]   rlevel_q, rlevel_d;

  // Output buffer flops; inflight marks a memory read whose data lands next cycle
  logic                inflight_q, inflight_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [DATASIZE-1:0] buf0_q, buf0_d;
  logic [DATASIZE-1:0] buf1_q, buf1_d;

  logic                pop;
  logic                ren_int;
  logic [1:0]          occ;
  logic [1:0]          occ_after_pop;
  logic [1:0]          base;
  logic [ADDRSIZE:0]   wbin_s;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Read issue decision and next pointer / status values
  always_comb begin
    pop           = (cnt_q != 2'd0) && dout_ready;
    // occ counts buffered words plus the read in flight; never exceeds 2
    occ           = cnt_q + {1'b0, inflight_q};
    occ_after_pop = occ - {1'b0, pop};
    ren_int       = !empty_q && (occ_after_pop < 2'd2);
    rbin_d        = rbin_q + {{ADDRSIZE{1'b0}}, ren_int};
    rptr_d        = rbin_d ^ (rbin_d >> 1);
    wbin_s        = gray2bin(wptr_sync);
    rlevel_d      = wbin_s - rbin_d;
    // empty is recomputed every cycle, so a one-cycle wptr_sync blip cannot
    // leave a stale non-empty flag behind
    empty_d       = (wptr_sync == rptr_d);
    aempty_d      = (rlevel_d <= THRESH);
    inflight_d    = ren_int;
  end

  // Output buffer: shift on pop, land returning memory data behind the survivors
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    base   = cnt_q - {1'b0, pop};
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if (base == 2'd0) begin
        buf0_d = rdata_mem;
      end else begin
        buf1_d = rdata_mem;
      end
    end
    cnt_d = base + {1'b0, inflight_q};
  end

  // State registers; reset also drops any read still in flight
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      empty_q    <= 1'b1;
      aempty_q   <= 1'b1;
      rlevel_q   <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      empty_q    <= empty_d;
      aempty_q   <= aempty_d;
      rlevel_q   <= rlevel_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  assign ren        = ren_int;
  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign empty      = empty_q;
  assign aempty     = aempty_q;
  assign rlevel     = rlevel_q;
  assign dout       = buf0_q;
  assign dout_valid = (cnt_q != 2'd0);

endmodule
